// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
//
// Shared definitions for the JTAG TAP controller:
//   - tap_state_e : 4-bit encoding of the 16 TAP states (also the value driven
//                   on jtag_tap_ctrl.tap_state)
//   - IR_BYPASS / IR_IDCODE / IR_USER : instruction opcodes, written as plain
//                   integers so they can be sized to any IR width with a cast
//                   (IR_BYPASS = -1 sizes to all ones)
//   - IR_CAPTURE  : fixed pattern loaded into the IR shift register in
//                   Capture-IR (zero-extended to the IR width)
//   - dr_sel_e    : which data register the current instruction selects
// -----------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

    localparam int IR_BYPASS = -1;
    localparam int IR_IDCODE = 1;
    localparam int IR_USER   = 2;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
//
// The 16-state IEEE 1149.1 TAP state machine. The state is a plain register
// clocked by tck; nothing downstream sees tms combinationally.
//
// Ports:
//   tck   in   test clock
//   trst  in   asynchronous active-low test reset (forces TLR)
//   tms   in   mode select, sampled on posedge tck
//   state out  current TAP state
// -----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_nxt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register updated on the same edge sees the pre-edge values of the others.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for state_nxt.
        state_nxt = state;
        case (state)
            TLR:     state_nxt = tms ? TLR    : RTI;
            RTI:     state_nxt = tms ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tms ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_tap_ctrl
//
// Slave-side JTAG TAP: TAP FSM, instruction register and the BYPASS, IDCODE
// and USER data registers. The USER register is exposed to on-chip logic.
//
// Build option:
//   JTAG_TAP_IDCODE_EN  defined   -> IDCODE DR present, TLR loads IR=IDCODE
//                       undefined -> no IDCODE DR, TLR loads IR=BYPASS and
//                                    opcode 1 decodes as BYPASS
//
// Ports:
//   tck            in   test clock
//   trst           in   asynchronous active-low test reset
//   tdi            in   serial data in (posedge tck)
//   tms            in   mode select (posedge tck)
//   tdo            out  serial data out (launched on negedge tck)
//   tdo_en         out  high while shifting IR or DR
//   tap_state      out  current TAP state (jtag_pkg::tap_state_e encoding)
//   ir_out         out  current (updated) instruction
//   user_dr_in     in   value captured at Capture-DR when USER is selected
//   user_dr_out    out  USER value latched at Update-DR
//   user_dr_update out  one-tck pulse when user_dr_out is written
// -----------------------------------------------------------------------------
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter int          USER_DR_WIDTH = 16,
    parameter logic [31:0] IDCODE_VAL    = 32'h1A2B_C3D5
) (
    input  logic                     tck,
    input  logic                     trst,
    input  logic                     tdi,
    input  logic                     tms,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_out,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_dr_update
);

    localparam logic [IR_WIDTH-1:0] OP_BYPASS  = IR_WIDTH'(IR_BYPASS);
    localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(IR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_RESET   = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] OP_RESET   = OP_BYPASS;
`endif

    // Elaboration-time parameter sanity checks.
    if (IR_WIDTH < 2) begin : g_bad_ir_width
        $error("jtag_tap_ctrl: IR_WIDTH must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
    end

    tap_state_e state;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    assign tap_state = state;

    // ---------------------------------------------------------------- IR path
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir       <= OP_RESET;
            ir_shift <= '0;
        end else begin
            case (state)
                TLR:     ir       <= OP_RESET;
                CAP_IR:  ir_shift <= IR_CAP_VAL;
                SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPD_IR:  ir       <= ir_shift;
                default: ;
            endcase
        end
    end

    assign ir_out = ir;

    // ------------------------------------------------------ instruction decode
    // Unknown opcodes fall through to BYPASS.
    dr_sel_e dr_sel;

    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir == OP_USER) begin
            dr_sel = SEL_USER;
        end
`ifdef JTAG_TAP_IDCODE_EN
        else if (ir == OP_IDCODE) begin
            dr_sel = SEL_IDCODE;
        end
`endif
    end

    // ---------------------------------------------------------------- DR path
    // Only the selected register captures or shifts; pause/exit states hold.
    logic                     bypass_reg;
    logic [USER_DR_WIDTH-1:0] user_shift;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0]              idcode_shift;
`endif

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass_reg   <= 1'b0;
            user_shift   <= '0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_shift <= '0;
`endif
        end else if (state == CAP_DR) begin
            case (dr_sel)
                SEL_USER:   user_shift   <= user_dr_in;
`ifdef JTAG_TAP_IDCODE_EN
                SEL_IDCODE: idcode_shift <= IDCODE_VAL;
`endif
                default:    bypass_reg   <= 1'b0;
            endcase
        end else if (state == SH_DR) begin
            case (dr_sel)
                SEL_USER:   user_shift   <= {tdi, user_shift[USER_DR_WIDTH-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
                SEL_IDCODE: idcode_shift <= {tdi, idcode_shift[31:1]};
`endif
                default:    bypass_reg   <= tdi;
            endcase
        end
    end

    // ------------------------------------------------------------ USER update
    // Only an Update-DR with USER selected commits; an aborted shift (trst)
    // never reaches this state, so partial data is never exposed.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            user_dr_out    <= '0;
            user_dr_update <= 1'b0;
        end else begin
            user_dr_update <= 1'b0;
            if (state == UPD_DR && dr_sel == SEL_USER) begin
                user_dr_out    <= user_shift;
                user_dr_update <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- tdo path
    logic dr_lsb;

    always_comb begin
        dr_lsb = bypass_reg;
        case (dr_sel)
            SEL_USER:   dr_lsb = user_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
            SEL_IDCODE: dr_lsb = idcode_shift[0];
`endif
            default:    dr_lsb = bypass_reg;
        endcase
    end

    // Launched on the falling edge so the master samples a stable bit on the
    // next rising edge; the first bit out is the captured LSB.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == SH_IR) begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
        end else if (state == SH_DR) begin
            tdo    <= dr_lsb;
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_ctrl
//
// Scoreboard bench for jtag_tap_ctrl. Scan tasks compute the expected tdo
// stream and USER updates from a transaction-level model (capture value
// followed by the shifted-in bits) and queue them; a monitor pops and compares
// whenever the DUT shifts (tdo_en) or pulses user_dr_update.
// Follows JTAG_TAP_IDCODE_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    localparam int          IRW = 4;
    localparam int          UW  = 16;
    localparam logic [31:0] IDV = 32'h1A2B_C3D5;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IRW-1:0] M_RESET_IR = 4'h1;
`else
    localparam logic [IRW-1:0] M_RESET_IR = 4'hF;
`endif

    logic           tck  = 1'b0;
    logic           trst = 1'b1;
    logic           tdi  = 1'b0;
    logic           tms  = 1'b1;
    logic           tdo;
    logic           tdo_en;
    logic [3:0]     tap_state;
    logic [IRW-1:0] ir_out;
    logic [UW-1:0]  user_dr_in = '0;
    logic [UW-1:0]  user_dr_out;
    logic           user_dr_update;

    jtag_tap_ctrl #(
        .IR_WIDTH      (IRW),
        .USER_DR_WIDTH (UW),
        .IDCODE_VAL    (IDV)
    ) dut (
        .tck            (tck),
        .trst           (trst),
        .tdi            (tdi),
        .tms            (tms),
        .tdo            (tdo),
        .tdo_en         (tdo_en),
        .tap_state      (tap_state),
        .ir_out         (ir_out),
        .user_dr_in     (user_dr_in),
        .user_dr_out    (user_dr_out),
        .user_dr_update (user_dr_update)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_errors = 0;
    int en_count = 0;

    bit            exp_tdo[$];
    logic [UW-1:0] exp_upd[$];

    // Reference model state.
    logic [IRW-1:0] m_ir;
    logic [UW-1:0]  m_user_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic [UW-1:0] upd_val;
    bit            tdo_val;

    initial begin
        forever begin
            @(negedge tck);
            #1;
            if (tdo_en === 1'b1) begin
                en_count++;
                if (exp_tdo.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tdo_extra: shifted bit %b, none expected (t=%0t)", tdo, $time);
                end else begin
                    tdo_val = exp_tdo.pop_front();
                    check("tdo_bit", 64'(tdo), 64'(tdo_val));
                end
            end else begin
                check("tdo_idle_zero", 64'(tdo), 64'(0));
            end
            if (user_dr_update === 1'b1) begin
                if (exp_upd.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL update_extra: pulse with user_dr_out=0x%0h, none expected (t=%0t)",
                             user_dr_out, $time);
                end else begin
                    upd_val = exp_upd.pop_front();
                    check("user_dr_out_at_pulse", 64'(user_dr_out), 64'(upd_val));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- stimulus
    // Inputs change 1 ns after posedge; the DUT samples them on the next one.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // DR scan from RTI back to RTI, n bits of d shifted LSB first.
    task automatic dr_scan(input int n, input logic [63:0] d);
        bit            q[$];
        int            w;
        logic [63:0]   cap;
        logic [UW-1:0] nv;
        bit            is_user;
        int            start;
        is_user = (m_ir == 4'h2);
        if (is_user) begin
            w   = UW;
            cap = 64'(user_dr_in);
        end
`ifdef JTAG_TAP_IDCODE_EN
        else if (m_ir == 4'h1) begin
            w   = 32;
            cap = 64'(IDV);
        end
`endif
        else begin
            w   = 1;
            cap = '0;
        end
        for (int i = 0; i < w; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        for (int i = 0; i < n; i++) exp_tdo.push_back(q[i]);
        start = en_count;
        step(1'b1, 1'b0);  // SEL_DR
        step(1'b0, 1'b0);  // CAP_DR
        step(1'b0, 1'b0);  // capture edge -> SH_DR
        for (int i = 0; i < n; i++) step(i == n - 1, d[i]);
        step(1'b1, 1'b0);  // EX1_DR -> UPD_DR
        if (is_user) begin
            for (int j = 0; j < UW; j++) nv[j] = q[n + j];
            m_user_out = nv;
            exp_upd.push_back(nv);
        end
        step(1'b0, 1'b0);  // update edge -> RTI
        check("dr_scan_end_state", 64'(tap_state), 64'(RTI));
        check("dr_scan_tdo_en_count", 64'(en_count - start), 64'(n));
        check("dr_scan_user_dr_out", 64'(user_dr_out), 64'(m_user_out));
    endtask

    // IR scan from RTI back to RTI.
    task automatic ir_scan(input int n, input logic [63:0] d);
        bit q[$];
        int start;
        for (int i = 0; i < IRW; i++) q.push_back(i == 0);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        for (int i = 0; i < n; i++) exp_tdo.push_back(q[i]);
        start = en_count;
        step(1'b1, 1'b0);  // SEL_DR
        step(1'b1, 1'b0);  // SEL_IR
        step(1'b0, 1'b0);  // CAP_IR
        step(1'b0, 1'b0);  // capture edge -> SH_IR
        for (int i = 0; i < n; i++) step(i == n - 1, d[i]);
        step(1'b1, 1'b0);  // EX1_IR -> UPD_IR
        for (int j = 0; j < IRW; j++) m_ir[j] = q[n + j];
        step(1'b0, 1'b0);  // update edge -> RTI
        check("ir_scan_end_state", 64'(tap_state), 64'(RTI));
        check("ir_scan_tdo_en_count", 64'(en_count - start), 64'(n));
        check("ir_out_after_update", 64'(ir_out), 64'(m_ir));
    endtask

    logic [63:0]    rnd;
    logic [IRW-1:0] op;
    int             len;
    int             start_cnt;

    initial begin
        m_ir       = M_RESET_IR;
        m_user_out = '0;

        // Reset
        tms = 1'b1;
        #2 trst = 1'b0;
        @(posedge tck);
        #1;
        check("reset_state", 64'(tap_state), 64'(TLR));
        check("reset_ir", 64'(ir_out), 64'(M_RESET_IR));
        check("reset_user_dr_out", 64'(user_dr_out), 64'(0));
        check("reset_update", 64'(user_dr_update), 64'(0));
        check("reset_tdo_en", 64'(tdo_en), 64'(0));
        @(posedge tck);
        #1;
        trst = 1'b1;
        step(1'b1, 1'b0);
        check("tlr_hold", 64'(tap_state), 64'(TLR));
        step(1'b0, 1'b0);
        check("tlr_to_rti", 64'(tap_state), 64'(RTI));

        // Default-instruction DR scan (IDCODE or BYPASS depending on build)
        dr_scan(32, {$urandom, $urandom});

        // IR all ones, then bypass behaviour
        ir_scan(4, 64'hF);
        dr_scan(4, 64'b1101);

        // USER write then USER capture
        ir_scan(4, 64'h2);
        user_dr_in = 16'($urandom);
        dr_scan(16, 64'hA5C3);
        check("user_write_value", 64'(user_dr_out), 64'hA5C3);
        user_dr_in = 16'h5A3C;
        dr_scan(16, {$urandom, $urandom});

        // Opcode 1: IDCODE if built in, otherwise bypass
        ir_scan(4, 64'h1);
        dr_scan(8, {$urandom, $urandom});

        // Five tms=1 from PAU_DR reaches TLR; USER output untouched
        ir_scan(4, 64'h5);
        rnd = {$urandom, $urandom};
        exp_tdo.push_back(1'b0);
        exp_tdo.push_back(rnd[0]);
        exp_tdo.push_back(rnd[1]);
        start_cnt = en_count;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, rnd[0]);
        step(1'b0, rnd[1]);
        step(1'b1, rnd[2]);
        step(1'b0, 1'b0);
        check("pause_state", 64'(tap_state), 64'(PAU_DR));
        check("pause_tdo_en_count", 64'(en_count - start_cnt), 64'(3));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("five_tms_tlr", 64'(tap_state), 64'(TLR));
        step(1'b1, 1'b0);
        m_ir = M_RESET_IR;
        check("tlr_reload_ir", 64'(ir_out), 64'(m_ir));
        check("tlr_user_unchanged", 64'(user_dr_out), 64'(m_user_out));
        step(1'b0, 1'b0);

        // Randomised scans
        for (int t = 0; t < 30; t++) begin
            rnd = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       op = 4'h1;
                    1:       op = 4'h2;
                    2:       op = 4'hF;
                    default: op = 4'($urandom);
                endcase
                len = $urandom_range(4, 10);
                rnd[len - 4 +: 4] = op;
                ir_scan(len, rnd);
            end else begin
                user_dr_in = 16'($urandom);
                len = $urandom_range(1, 48);
                dr_scan(len, rnd);
            end
        end

        // trst mid-way through a USER shift: abort, nothing committed
        ir_scan(4, 64'h2);
        if (m_user_out == '0) dr_scan(16, 64'h0001);
        user_dr_in = 16'($urandom);
        rnd = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) exp_tdo.push_back(user_dr_in[i]);
        start_cnt = en_count;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, rnd[i]);
        #1;
        trst = 1'b0;
        tms  = 1'b1;
        #1;
        m_ir       = M_RESET_IR;
        m_user_out = '0;
        check("abort_state", 64'(tap_state), 64'(TLR));
        check("abort_tdo_en", 64'(tdo_en), 64'(0));
        check("abort_tdo", 64'(tdo), 64'(0));
        check("abort_user_dr_out", 64'(user_dr_out), 64'(0));
        check("abort_ir", 64'(ir_out), 64'(M_RESET_IR));
        check("abort_tdo_en_count", 64'(en_count - start_cnt), 64'(5));
        @(posedge tck);
        @(posedge tck);
        #1;
        trst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("post_abort_user_dr_out", 64'(user_dr_out), 64'(0));
        dr_scan(8, {$urandom, $urandom});

        // Drain
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("tdo_queue_drained", 64'(exp_tdo.size()), 64'(0));
        check("update_queue_drained", 64'(exp_upd.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
